// File: rtl/serial_101_framer.sv
// Serial "101"-delimited frame transmitter: accepts a parallel word over
// valid/ready, sends a 1-0-1 preamble, the zero-stuffed payload LSB first,
// then a run of idle zeros so the pattern 1-0-1 marks only frame starts.
module serial_101_framer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned GAP    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid,
  output logic              ready,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned GAP_W = $clog2(GAP + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_DATA  = 3'd2,
    S_STUFF = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t              state_q, state_n;
  logic [DATA_W-1:0]   sh_q, sh_n;
  logic [IDX_W-1:0]    idx_q, idx_n;
  logic [GAP_W-1:0]    gap_q, gap_n;
  logic [1:0]          pre_q, pre_n;
  logic                prev_q, prev_n;
  logic                tx_n, ready_n, busy_n, frame_done_n;
  logic                stuff_c;

  // Last two emitted bits are 1 then 0: the next bit must be a stuffed 0.
  assign stuff_c = prev_q && !tx;

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      sh_q       <= '0;
      idx_q      <= '0;
      gap_q      <= '0;
      pre_q      <= '0;
      prev_q     <= 1'b0;
      tx         <= 1'b0;
      ready      <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_n;
      sh_q       <= sh_n;
      idx_q      <= idx_n;
      gap_q      <= gap_n;
      pre_q      <= pre_n;
      prev_q     <= prev_n;
      tx         <= tx_n;
      ready      <= ready_n;
      busy       <= busy_n;
      frame_done <= frame_done_n;
    end
  end

  // Next state and next value of every registered output.
  always_comb begin
    state_n      = state_q;
    sh_n         = sh_q;
    idx_n        = idx_q;
    gap_n        = gap_q;
    pre_n        = pre_q;
    prev_n       = tx;
    tx_n         = 1'b0;
    frame_done_n = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (valid) begin
          state_n = S_PRE;
          sh_n    = data_in;
          pre_n   = 2'd0;
          tx_n    = 1'b1;
        end
      end

      S_PRE: begin
        if (pre_q == 2'd0) begin
          pre_n = 2'd1;
          tx_n  = 1'b0;
        end else if (pre_q == 2'd1) begin
          pre_n = 2'd2;
          tx_n  = 1'b1;
        end else begin
          state_n = S_DATA;
          idx_n   = '0;
          tx_n    = sh_q[0];
          sh_n    = sh_q >> 1;
        end
      end

      S_DATA: begin
        if (stuff_c) begin
          state_n = S_STUFF;
          tx_n    = 1'b0;
        end else if (idx_q == LAST_IDX) begin
          state_n = S_GAP;
          gap_n   = '0;
        end else begin
          idx_n = idx_q + IDX_W'(1);
          tx_n  = sh_q[0];
          sh_n  = sh_q >> 1;
        end
      end

      // A stuffed 0 leaves history 0,0, so the next step never stuffs again.
      S_STUFF: begin
        if (idx_q == LAST_IDX) begin
          state_n = S_GAP;
          gap_n   = '0;
        end else begin
          state_n = S_DATA;
          idx_n   = idx_q + IDX_W'(1);
          tx_n    = sh_q[0];
          sh_n    = sh_q >> 1;
        end
      end

      S_GAP: begin
        if (gap_q == LAST_GAP) begin
          state_n      = S_IDLE;
          frame_done_n = 1'b1;
        end else begin
          gap_n = gap_q + GAP_W'(1);
        end
      end

      default: state_n = S_IDLE;
    endcase

    ready_n = (state_n == S_IDLE);
    busy_n  = (state_n != S_IDLE);
  end

endmodule

// File: tb/tb_serial_101_framer.sv
// Bench for serial_101_framer: directed frames plus a randomized stream,
// checked against a bit-list frame model and a looped-back 1-0-1 detector.
module tb_serial_101_framer;

  localparam int unsigned DW    = 8;
  localparam int unsigned GAP_P = 2;
  localparam int          NRAND = 1000;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] data_in;
  logic          valid;
  logic          ready;
  logic          tx;
  logic          busy;
  logic          frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  bit            txq[$];
  bit            exp_q[$];
  logic [DW-1:0] dec_q[$];
  int            fd_cnt;
  int            rdy_low;

  serial_101_framer #(.DATA_W(DW), .GAP(GAP_P)) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .valid      (valid),
    .ready      (ready),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Capture the serial line and pulse counts mid-cycle.
  always @(negedge clk) begin
    txq.push_back(tx);
    if (frame_done === 1'b1) fd_cnt++;
    if (ready === 1'b0) rdy_low++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    txq.delete();
    fd_cnt  = 0;
    rdy_low = 0;
  endtask

  // Expected line bits of one frame: preamble, stuffed payload, gap zeros.
  function automatic void model_frame(input logic [DW-1:0] w);
    int n;
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    for (int k = 0; k < DW; k++) begin
      exp_q.push_back(w[k]);
      n = exp_q.size();
      if (exp_q[n-2] == 1'b1 && exp_q[n-1] == 1'b0) exp_q.push_back(1'b0);
    end
    for (int g = 0; g < GAP_P; g++) exp_q.push_back(1'b0);
  endfunction

  // Number of 1-0-1 windows seen by a detector on the captured line.
  function automatic int count_101();
    int n = 0;
    for (int i = 2; i < txq.size(); i++)
      if (txq[i-2] && !txq[i-1] && txq[i]) n++;
    return n;
  endfunction

  // Index where the first 1-0-1 window completes, or -1.
  function automatic int first_101();
    for (int i = 2; i < txq.size(); i++)
      if (txq[i-2] && !txq[i-1] && txq[i]) return i;
    return -1;
  endfunction

  // First index where the captured line differs from the expected bits.
  function automatic int stream_diff();
    if (txq.size() < exp_q.size()) return txq.size();
    for (int i = 0; i < exp_q.size(); i++)
      if (txq[i] != exp_q[i]) return i;
    return -1;
  endfunction

  // Receiver view: find each preamble and de-stuff the following payload.
  function automatic void decode_stream();
    int            i, j;
    logic [DW-1:0] w;
    bit            ok;
    dec_q.delete();
    i = 0;
    while (i + 2 < txq.size()) begin
      if (txq[i] && !txq[i+1] && txq[i+2]) begin
        j  = i + 3;
        w  = '0;
        ok = 1'b1;
        for (int k = 0; k < DW; k++) begin
          if (j >= txq.size()) begin
            ok = 1'b0;
            break;
          end
          w[k] = txq[j];
          j++;
          if (txq[j-2] && !txq[j-1]) j++;
        end
        if (ok) dec_q.push_back(w);
        i = j;
      end else begin
        i++;
      end
    end
  endfunction

  task automatic test_reset();
    reset = 1'b1; valid = 1'b0; data_in = '0;
    tick(); tick();
    n_checks++; if (tx !== 1'b0)         begin n_fail++; $display("FAIL reset_tx: got %b expected 0", tx); end
    n_checks++; if (ready !== 1'b1)      begin n_fail++; $display("FAIL reset_ready: got %b expected 1", ready); end
    n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    reset = 1'b0;
    tick(); tick();
    n_checks++; if (ready !== 1'b1 || tx !== 1'b0) begin n_fail++; $display("FAIL idle_hold: ready=%b tx=%b expected 1/0", ready, tx); end
  endtask

  // One frame with a single valid pulse; payload length given from hand analysis.
  task automatic run_single(input logic [DW-1:0] w, input int exp_payload);
    int cyc;
    int d;
    int exp_len;
    exp_len = 3 + exp_payload + GAP_P;
    exp_q.delete();
    model_frame(w);
    data_in = w; valid = 1'b1;
    tick();
    valid = 1'b0; data_in = ~w;
    clear_mon();
    n_checks++; if (ready !== 1'b0 || busy !== 1'b1 || tx !== 1'b1) begin n_fail++; $display("FAIL accept_%h: ready=%b busy=%b tx=%b expected 0/1/1", w, ready, busy, tx); end
    cyc = 0;
    while (!ready && cyc < 200) begin tick(); cyc++; end
    n_checks++; if (cyc !== exp_len) begin n_fail++; $display("FAIL frame_len_%h: got %0d expected %0d", w, cyc, exp_len); end
    n_checks++; if (rdy_low !== exp_len) begin n_fail++; $display("FAIL ready_low_%h: got %0d expected %0d", w, rdy_low, exp_len); end
    n_checks++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL done_pulse_%h: got %b expected 1", w, frame_done); end
    d = stream_diff();
    n_checks++; if (d !== -1) begin n_fail++; $display("FAIL stream_%h: first difference at bit %0d expected none", w, d); end
    tick();
    n_checks++; if (frame_done !== 1'b0 || fd_cnt !== 1) begin n_fail++; $display("FAIL done_once_%h: frame_done=%b count=%0d expected 0/1", w, frame_done, fd_cnt); end
    n_checks++; if (count_101() !== 1) begin n_fail++; $display("FAIL z_count_%h: got %0d expected 1", w, count_101()); end
    n_checks++; if (first_101() !== 2) begin n_fail++; $display("FAIL z_pos_%h: got %0d expected 2", w, first_101()); end
  endtask

  task automatic test_basic();
    logic [14:0] golden;
    golden = 15'b101_1001000000_00;
    run_single(8'h05, 10);
    for (int i = 0; i < 15; i++) begin
      n_checks++;
      if (txq[i] !== golden[14-i]) begin n_fail++; $display("FAIL golden_05 bit %0d: got %b expected %b", i, txq[i], golden[14-i]); end
    end
    run_single(8'h00, 9);
    run_single(8'hAA, 12);
  endtask

  task automatic test_back_to_back();
    int cyc;
    int d;
    exp_q.delete();
    model_frame(8'hFF);
    exp_q.push_back(1'b0);
    model_frame(8'h55);
    data_in = 8'hFF; valid = 1'b1;
    tick();
    clear_mon();
    data_in = 8'h55;
    cyc = 0;
    while (!ready && cyc < 200) begin tick(); cyc++; end
    n_checks++; if (cyc !== 13) begin n_fail++; $display("FAIL b2b_len1: got %0d expected 13", cyc); end
    n_checks++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL b2b_done1: got %b expected 1", frame_done); end
    tick();
    n_checks++; if (ready !== 1'b0 || tx !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: ready=%b tx=%b expected 0/1", ready, tx); end
    valid = 1'b0;
    cyc = 0;
    while (!ready && cyc < 200) begin tick(); cyc++; end
    n_checks++; if (cyc !== 17) begin n_fail++; $display("FAIL b2b_len2: got %0d expected 17", cyc); end
    tick();
    n_checks++; if (fd_cnt !== 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d expected 2", fd_cnt); end
    n_checks++; if (count_101() !== 2) begin n_fail++; $display("FAIL b2b_z_count: got %0d expected 2", count_101()); end
    d = stream_diff();
    n_checks++; if (d !== -1) begin n_fail++; $display("FAIL b2b_stream: first difference at bit %0d expected none", d); end
  endtask

  task automatic test_reset_mid_frame();
    data_in = 8'h3C; valid = 1'b1;
    tick();
    valid = 1'b0;
    tick(); tick(); tick(); tick();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_in_frame: busy=%b expected 1", busy); end
    reset = 1'b1;
    tick();
    n_checks++; if (tx !== 1'b0 || ready !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
      n_fail++; $display("FAIL abort_outputs: tx=%b ready=%b busy=%b frame_done=%b expected 0/1/0/0", tx, ready, busy, frame_done);
    end
    reset = 1'b0;
    clear_mon();
    tick(); tick(); tick();
    n_checks++; if (fd_cnt !== 0 || ready !== 1'b1) begin n_fail++; $display("FAIL abort_no_done: count=%0d ready=%b expected 0/1", fd_cnt, ready); end
    run_single(8'h96, 11);
  endtask

  task automatic test_random();
    logic [DW-1:0] words[$];
    int            i, cyc, idle_wait, bad;
    logic          rdy_before, v;
    for (int k = 0; k < NRAND; k++) words.push_back(DW'($urandom));
    clear_mon();
    i = 0; cyc = 0; idle_wait = 0;
    while (i < NRAND && cyc < 60000) begin
      if (idle_wait > 0) begin
        valid = 1'b0; data_in = DW'($urandom); idle_wait--;
      end else begin
        valid = 1'b1; data_in = words[i];
      end
      rdy_before = ready; v = valid;
      tick(); cyc++;
      if (v && rdy_before) begin
        i++;
        idle_wait = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : 0;
        if (!v) idle_wait = 0;
      end else if (!v) begin
        data_in = DW'($urandom);
      end
    end
    valid = 1'b0;
    n_checks++; if (i !== NRAND) begin n_fail++; $display("FAIL rand_sent: got %0d expected %0d", i, NRAND); end
    cyc = 0;
    while (!ready && cyc < 200) begin tick(); cyc++; end
    tick(); tick();
    n_checks++; if (count_101() !== NRAND) begin n_fail++; $display("FAIL rand_z_count: got %0d expected %0d", count_101(), NRAND); end
    n_checks++; if (fd_cnt !== NRAND) begin n_fail++; $display("FAIL rand_done_count: got %0d expected %0d", fd_cnt, NRAND); end
    decode_stream();
    n_checks++; if (dec_q.size() !== NRAND) begin n_fail++; $display("FAIL rand_decoded: got %0d expected %0d", dec_q.size(), NRAND); end
    bad = 0;
    for (int k = 0; k < NRAND && k < dec_q.size(); k++) begin
      n_checks++;
      if (dec_q[k] !== words[k]) begin
        n_fail++; bad++;
        if (bad <= 20) $display("FAIL rand_word %0d: got %h expected %h", k, dec_q[k], words[k]);
      end
    end
  endtask

  initial begin
    reset = 1'b1; valid = 1'b0; data_in = '0;
    test_reset();
    test_basic();
    tick(); tick();
    test_back_to_back();
    tick(); tick();
    test_reset_mid_frame();
    tick(); tick();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
